// File: rtl/ff_delay_line.sv
// Fixed-depth register delay line with clock enable, flush, per-stage valid bits
// and a running count of occupied stages. DEPTH=1 degenerates to an enabled D flip-flop.
module ff_delay_line #(
    parameter int unsigned      WIDTH     = 8,
    parameter int unsigned      DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           din,
    input  logic                       din_valid,
    output logic [WIDTH-1:0]           dout,
    output logic                       dout_valid,
    output logic [WIDTH*DEPTH-1:0]     taps,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [CW-1:0]    count_q, count_d;

    // Flush only clears occupancy; stage data stays so taps remain stable.
    always_comb begin
        stage_d = stage_q;
        valid_d = valid_q;
        count_d = count_q;
        if (flush) begin
            valid_d = '0;
            count_d = '0;
        end else if (en) begin
            stage_d[0] = din;
            valid_d[0] = din_valid;
            for (int unsigned k = 1; k < DEPTH; k++) begin
                stage_d[k] = stage_q[k-1];
                valid_d[k] = valid_q[k-1];
            end
            count_d = count_q + CW'(din_valid) - CW'(valid_q[DEPTH-1]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                stage_q[k] <= RESET_VAL;
            end
            valid_q <= '0;
            count_q <= '0;
        end else begin
            stage_q <= stage_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        taps = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            taps[k*WIDTH +: WIDTH] = stage_q[k];
        end
    end

    assign dout       = stage_q[DEPTH-1];
    assign dout_valid = valid_q[DEPTH-1];
    assign count      = count_q;

endmodule

// File: tb/tb_ff_delay_line.sv
// Bench for ff_delay_line: hand-computed vector table plus a stage-queue scoreboard
// on a DEPTH=4 instance, and a short hand sequence on a DEPTH=1 instance.
module tb_ff_delay_line;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, en, flush, din_valid;
    logic [7:0]  din, dout;
    logic        dout_valid;
    logic [31:0] taps;
    logic [2:0]  count;

    ff_delay_line #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'hA5)) dut (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .din(din), .din_valid(din_valid),
        .dout(dout), .dout_valid(dout_valid), .taps(taps), .count(count)
    );

    logic       rst1, en1, dinv1, dv1o;
    logic [7:0] din1, dout1, taps1;
    logic [0:0] cnt1;

    ff_delay_line #(.WIDTH(8), .DEPTH(1)) dut1 (
        .clk(clk), .rst(rst1), .en(en1), .flush(1'b0), .din(din1), .din_valid(dinv1),
        .dout(dout1), .dout_valid(dv1o), .taps(taps1), .count(cnt1)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        bit         r, f, e;
        logic [7:0] d;
        bit         v;
        logic [7:0] xd;
        bit         xv;
        int         xc;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input bit r, input bit f, input bit e, input logic [7:0] d, input bit v,
                       input logic [7:0] xd, input bit xv, input int xc);
        vec_t t;
        t.r = r; t.f = f; t.e = e; t.d = d; t.v = v;
        t.xd = xd; t.xv = xv; t.xc = xc;
        vecs.push_back(t);
    endtask

    // Scoreboard: entry 0 is the oldest stage (DEPTH-1); enabled edges push new, pop oldest.
    typedef struct {
        logic [7:0] d;
        bit         v;
    } ent_t;
    ent_t mq[$];

    task automatic model_edge();
        ent_t e;
        if (rst) begin
            mq.delete();
            e.d = 8'hA5;
            e.v = 1'b0;
            for (int k = 0; k < 4; k++) mq.push_back(e);
        end else if (flush) begin
            foreach (mq[k]) mq[k].v = 1'b0;
        end else if (en) begin
            void'(mq.pop_front());
            e.d = din;
            e.v = din_valid;
            mq.push_back(e);
        end
    endtask

    task automatic model_check(input int step);
        logic [31:0] xt;
        int          pc;
        pc = 0;
        for (int k = 0; k < 4; k++) begin
            xt[k*8 +: 8] = mq[3-k].d;
            pc += int'(mq[k].v);
        end
        chk($sformatf("sb_taps[%0d]", step), taps, xt);
        chk($sformatf("sb_dout[%0d]", step), 32'(dout), 32'(mq[0].d));
        chk($sformatf("sb_dvalid[%0d]", step), 32'(dout_valid), 32'(mq[0].v));
        chk($sformatf("sb_count[%0d]", step), 32'(count), 32'(pc));
    endtask

    initial begin
        logic [31:0] taps_pre;
        rst = 1'b1; en = 1'b0; flush = 1'b0; din = '0; din_valid = 1'b0;
        rst1 = 1'b1; en1 = 1'b0; din1 = '0; dinv1 = 1'b0;

        //  r  f  e  din    v  dout   dv cnt
        // reset
        add(1, 0, 0, 8'h00, 0, 8'hA5, 0, 0);
        add(1, 0, 0, 8'h00, 0, 8'hA5, 0, 0);
        // latency
        add(0, 0, 1, 8'h01, 1, 8'hA5, 0, 1);
        add(0, 0, 1, 8'h02, 1, 8'hA5, 0, 2);
        add(0, 0, 1, 8'h03, 1, 8'hA5, 0, 3);
        add(0, 0, 1, 8'h04, 1, 8'h01, 1, 4);
        add(0, 0, 1, 8'h00, 0, 8'h02, 1, 3);
        add(0, 0, 1, 8'h00, 0, 8'h03, 1, 2);
        add(0, 0, 1, 8'h00, 0, 8'h04, 1, 1);
        add(0, 0, 1, 8'h00, 0, 8'h00, 0, 0);
        // stall
        add(0, 0, 1, 8'h11, 1, 8'h00, 0, 1);
        add(0, 0, 1, 8'h22, 1, 8'h00, 0, 2);
        add(0, 0, 0, 8'hEE, 1, 8'h00, 0, 2);
        add(0, 0, 0, 8'hEE, 1, 8'h00, 0, 2);
        add(0, 0, 0, 8'hEE, 1, 8'h00, 0, 2);
        add(0, 0, 1, 8'h00, 0, 8'h00, 0, 2);
        add(0, 0, 1, 8'h00, 0, 8'h11, 1, 2);
        add(0, 0, 1, 8'h00, 0, 8'h22, 1, 1);
        add(0, 0, 1, 8'h00, 0, 8'h00, 0, 0);
        // bubbles
        add(0, 0, 1, 8'h31, 1, 8'h00, 0, 1);
        add(0, 0, 1, 8'h32, 0, 8'h00, 0, 1);
        add(0, 0, 1, 8'h33, 1, 8'h00, 0, 2);
        add(0, 0, 1, 8'h34, 1, 8'h31, 1, 3);
        add(0, 0, 1, 8'h35, 0, 8'h32, 0, 2);
        add(0, 0, 1, 8'h00, 0, 8'h33, 1, 2);
        add(0, 0, 1, 8'h00, 0, 8'h34, 1, 1);
        add(0, 0, 1, 8'h00, 0, 8'h35, 0, 0);
        // flush collision
        add(0, 0, 1, 8'h41, 1, 8'h00, 0, 1);
        add(0, 0, 1, 8'h42, 1, 8'h00, 0, 2);
        add(0, 0, 1, 8'h43, 1, 8'h00, 0, 3);
        add(0, 0, 1, 8'h44, 1, 8'h41, 1, 4);
        add(0, 1, 1, 8'hFF, 1, 8'h41, 0, 0);
        add(0, 0, 1, 8'h00, 0, 8'h42, 0, 0);
        add(0, 0, 1, 8'h00, 0, 8'h43, 0, 0);
        add(0, 0, 1, 8'h00, 0, 8'h44, 0, 0);
        add(0, 0, 1, 8'h00, 0, 8'h00, 0, 0);
        // reset mid-stream (rst wins over en)
        add(0, 0, 1, 8'h51, 1, 8'h00, 0, 1);
        add(0, 0, 1, 8'h52, 1, 8'h00, 0, 2);
        add(0, 0, 1, 8'h53, 1, 8'h00, 0, 3);
        add(1, 0, 1, 8'h54, 1, 8'hA5, 0, 0);
        add(0, 0, 1, 8'h00, 0, 8'hA5, 0, 0);

        foreach (vecs[i]) begin
            rst = vecs[i].r; flush = vecs[i].f; en = vecs[i].e;
            din = vecs[i].d; din_valid = vecs[i].v;
            taps_pre = taps;
            @(posedge clk);
            model_edge();
            #1;
            model_check(i);
            chk($sformatf("tbl_dout[%0d]", i), 32'(dout), 32'(vecs[i].xd));
            chk($sformatf("tbl_dvalid[%0d]", i), 32'(dout_valid), 32'(vecs[i].xv));
            chk($sformatf("tbl_count[%0d]", i), 32'(count), 32'(vecs[i].xc));
            if (vecs[i].r && i == 1) chk("reset_taps", taps, 32'hA5A5A5A5);
            if (vecs[i].f && !vecs[i].r) chk($sformatf("flush_taps[%0d]", i), taps, taps_pre);
        end

        // DEPTH=1: enabled, resettable D flip-flop
        @(posedge clk); #1;
        chk("d1_reset_dout", 32'(dout1), 32'h00);
        chk("d1_reset_count", 32'(cnt1), 32'd0);
        chk("d1_reset_dvalid", 32'(dv1o), 32'd0);
        rst1 = 1'b0; en1 = 1'b1; din1 = 8'h3C; dinv1 = 1'b1;
        @(posedge clk); #1;
        chk("d1_load_dout", 32'(dout1), 32'h3C);
        chk("d1_load_taps", 32'(taps1), 32'h3C);
        chk("d1_load_dvalid", 32'(dv1o), 32'd1);
        chk("d1_load_count", 32'(cnt1), 32'd1);
        en1 = 1'b0; din1 = 8'h99; dinv1 = 1'b0;
        @(posedge clk); #1;
        chk("d1_hold_dout", 32'(dout1), 32'h3C);
        chk("d1_hold_count", 32'(cnt1), 32'd1);
        en1 = 1'b1; din1 = 8'h7E; dinv1 = 1'b0;
        @(posedge clk); #1;
        chk("d1_bubble_dout", 32'(dout1), 32'h7E);
        chk("d1_bubble_dvalid", 32'(dv1o), 32'd0);
        chk("d1_bubble_count", 32'(cnt1), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
